// File: rtl/vid_line_fetch.sv
// rtl/vid_line_fetch.sv - scan-line prefetcher from an MCB read port into a ping-pong line buffer
//
// Purpose:
//   On frame_start or line_req, reads one framebuffer scan line (BEATS x 128-bit)
//   from DRAM through a dedicated MCB read port and writes it into the bank that
//   the video path is not reading. The video path reads 32-bit words of the other
//   bank through buf_adr/buf_data.
//
// Parameters:
//   BEATS  128-bit beats per scan line (power of two, 2..32)
//   LINES  visible lines per frame
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   fb_base             framebuffer byte address, sampled on frame_start (bits [3:0] ignored)
//   frame_start         start of frame: restart at line 0 of fb_base
//   line_req            consumer switched banks: refill the freed bank
//   cmd_en/cmd_instr/cmd_bl/cmd_byte_addr/cmd_full   MCB command port (read)
//   rd_en/rd_data/rd_empty                           MCB read FIFO (first-word-fall-through)
//   buf_adr             {bank, beat, word[1:0]} read address of the line buffer
//   buf_data            selected 32-bit word, one clock after buf_adr
//   disp_bank           bank the consumer must read
//   busy                fetch in progress (CMD through DONE)
//   line_cnt            lines fetched this frame
//   underrun            sticky: line_req arrived while a fetch was in progress
//   underrun_cnt        saturating underrun count
//
// Configuration:
//   LINE_FETCH_UNDERRUN_EN  when defined, underrun/underrun_cnt are implemented;
//                           otherwise both are tied to zero. Queueing of a line_req
//                           that arrives while busy works the same in both builds.

module vid_line_fetch #(
    parameter int BEATS = 8,
    parameter int LINES = 768
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [29:0]               fb_base,
    input  logic                      frame_start,
    input  logic                      line_req,
    output logic                      cmd_en,
    output logic [2:0]                cmd_instr,
    output logic [5:0]                cmd_bl,
    output logic [29:0]               cmd_byte_addr,
    input  logic                      cmd_full,
    output logic                      rd_en,
    input  logic [127:0]              rd_data,
    input  logic                      rd_empty,
    input  logic [$clog2(BEATS)+2:0]  buf_adr,
    output logic [31:0]               buf_data,
    output logic                      disp_bank,
    output logic                      busy,
    output logic [9:0]                line_cnt,
    output logic                      underrun,
    output logic [15:0]               underrun_cnt
);

    localparam int              BW         = $clog2(BEATS);
    localparam logic [BW-1:0]   LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [9:0]      LINES_V    = 10'(LINES);
    localparam logic [29:0]     LINE_BYTES = 30'(BEATS * 16);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    state_t         state;
    logic [29:0]    addr;
    logic           fill_bank;
    logic           pending;
    logic           abort;
    logic [BW-1:0]  beat;

    logic [127:0]   line_buf [0:2*BEATS-1];

    logic           last_beat;
    logic           lines_left;
    logic           buf_we;
    logic [29:0]    base_aligned;
    logic [127:0]   rd_entry;
    logic           unused_fb_lsb;

    // Command fields are fixed; the address register is the line start address.
    assign cmd_instr     = 3'b001;
    assign cmd_bl        = 6'(BEATS - 1);
    assign cmd_byte_addr = addr;

    // Handshake strobes must react to cmd_full/rd_empty in the same cycle, so they
    // are decoded from the registered state rather than registered themselves.
    assign cmd_en = (state == S_CMD) && !cmd_full;
    assign rd_en  = (state == S_DATA) && !rd_empty;

    assign last_beat    = rd_en && (beat == LAST_BEAT);
    assign lines_left   = line_cnt < LINES_V;
    assign base_aligned = {fb_base[29:4], 4'b0000};
    assign unused_fb_lsb = ^fb_base[3:0];

    // Beats popped after an abort (or in the cycle frame_start arrives) belong to
    // the old frame and are dropped; they are still popped to drain the MCB FIFO.
    assign buf_we = rd_en && !abort && !frame_start;

    // Fetch sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            addr      <= '0;
            line_cnt  <= '0;
            fill_bank <= 1'b0;
            disp_bank <= 1'b1;
            pending   <= 1'b0;
            abort     <= 1'b0;
            beat      <= '0;
        end else if (frame_start) begin
            // frame_start wins over a simultaneous line_req.
            addr      <= base_aligned;
            line_cnt  <= '0;
            fill_bank <= 1'b0;
            disp_bank <= 1'b1;
            pending   <= 1'b0;
            if (rd_en) begin
                beat <= beat + 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_CMD;
                    busy  <= 1'b1;
                end
                S_CMD: begin
                    // A command not yet accepted simply retargets to the new base;
                    // one accepted this very cycle must have its data drained.
                    if (cmd_en) begin
                        state <= S_DATA;
                        beat  <= '0;
                        abort <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (last_beat) begin
                        state <= S_CMD;
                        abort <= 1'b0;
                    end else begin
                        abort <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end else begin
            if (line_req) begin
                disp_bank <= fill_bank;
            end
            // One-deep queue: a request during a fetch is remembered, repeats collapse.
            if (line_req && (state != S_IDLE) && lines_left) begin
                pending <= 1'b1;
            end
            if (rd_en) begin
                beat <= beat + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if ((line_req || pending) && lines_left) begin
                        fill_bank <= ~fill_bank;
                        pending   <= 1'b0;
                        state     <= S_CMD;
                        busy      <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (cmd_en) begin
                        state <= S_DATA;
                        beat  <= '0;
                    end
                end
                S_DATA: begin
                    // After draining an aborted command, go straight to line 0
                    // of the new frame; addr/line_cnt were already reloaded.
                    if (last_beat) begin
                        state <= abort ? S_CMD : S_DONE;
                        abort <= 1'b0;
                    end
                end
                S_DONE: begin
                    addr     <= addr + LINE_BYTES;
                    line_cnt <= line_cnt + 10'd1;
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer storage: entry index is {bank, beat}. Not reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[{fill_bank, beat}] <= rd_data;
        end
    end

    // Word 0 of a beat holds the leftmost pixels (rd_data[31:0]).
    assign rd_entry = line_buf[buf_adr[BW+2:2]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data <= '0;
        end else begin
            buf_data <= rd_entry[{buf_adr[1:0], 5'd0} +: 32];
        end
    end

`ifdef LINE_FETCH_UNDERRUN_EN
    logic underrun_evt;

    assign underrun_evt = line_req && !frame_start && (state != S_IDLE) && lines_left;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (underrun_evt) begin
            underrun <= 1'b1;
            if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`else
    assign underrun     = 1'b0;
    assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vid_line_fetch.sv
// tb/tb_vid_line_fetch.sv - scoreboard bench for vid_line_fetch with a behavioural MCB model

module tb_vid_line_fetch;

    localparam int BEATS = 8;
    localparam int BW    = 3;
    localparam int LINES = 768;
    localparam logic [29:0] LINE_BYTES = 30'(BEATS * 16);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [29:0]  fb_base = '0;
    logic         frame_start = 1'b0;
    logic         line_req = 1'b0;
    logic         cmd_en;
    logic [2:0]   cmd_instr;
    logic [5:0]   cmd_bl;
    logic [29:0]  cmd_byte_addr;
    logic         cmd_full = 1'b0;
    logic         rd_en;
    logic [127:0] rd_data = '0;
    logic         rd_empty = 1'b1;
    logic [BW+2:0] buf_adr = '0;
    logic [31:0]  buf_data;
    logic         disp_bank;
    logic         busy;
    logic [9:0]   line_cnt;
    logic         underrun;
    logic [15:0]  underrun_cnt;

    vid_line_fetch #(.BEATS(BEATS), .LINES(LINES)) dut (
        .clk(clk), .reset(reset), .fb_base(fb_base),
        .frame_start(frame_start), .line_req(line_req),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .buf_adr(buf_adr), .buf_data(buf_data), .disp_bank(disp_bank),
        .busy(busy), .line_cnt(line_cnt), .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [29:0]  exp_cmd[$];
    logic [31:0]  exp_word[$];
    logic [127:0] fifo[$];
    logic [127:0] all_beats[$];

    bit rand_stall = 0;
    bit alt_mode = 0;
    bit force_full = 0;
    bit adr_valid = 0;
    int pops_total = 0;
    int pop_limit = 1 << 30;
    int n_cmd = 0;
    int exp_ucnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // MCB model: a command queues BEATS random beats; pops take effect on the edge.
    initial begin : mcb_model
        bit do_pop, do_push, tog, stall;
        tog = 0;
        forever begin
            @(negedge clk);
            do_pop  = rd_en;
            do_push = cmd_en;
            @(posedge clk);
            #1;
            if (do_pop) begin
                compared++;
                if (fifo.size() == 0) begin
                    mismatched++;
                    $display("FAIL pop_empty: rd_en with no data queued (t=%0t)", $time);
                end else begin
                    void'(fifo.pop_front());
                end
                pops_total++;
            end
            if (do_push) begin
                for (int j = 0; j < BEATS; j++) begin
                    logic [127:0] w;
                    w = {$urandom, $urandom, $urandom, $urandom};
                    fifo.push_back(w);
                    all_beats.push_back(w);
                end
            end
            tog = ~tog;
            stall = (rand_stall && ($urandom_range(0, 9) < 3)) || (alt_mode && tog)
                    || (pops_total >= pop_limit);
            rd_empty = (fifo.size() == 0) || stall;
            rd_data  = (fifo.size() != 0) ? fifo[0] : {$urandom, $urandom, $urandom, $urandom};
            cmd_full = force_full || (rand_stall && ($urandom_range(0, 3) == 0));
        end
    end

    // Monitor: pops expected commands and buffer words as the DUT presents them.
    initial begin : monitor
        bit chk_next;
        logic [29:0] ea;
        logic [31:0] ew;
        chk_next = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cmd_en) begin
                    if (exp_cmd.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_cmd: addr %0h with none expected (t=%0t)", cmd_byte_addr, $time);
                    end else begin
                        ea = exp_cmd.pop_front();
                        check("cmd_byte_addr", cmd_byte_addr, ea);
                    end
                end
                if (rd_empty) check("rd_en_while_empty", rd_en, 0);
                if (chk_next) begin
                    if (exp_word.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL buf_word_underflow: got %0h with none expected", buf_data);
                    end else begin
                        ew = exp_word.pop_front();
                        check("buf_data", buf_data, ew);
                    end
                end
                chk_next = adr_valid;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input bit fs, input bit lr);
        @(posedge clk);
        #1;
        frame_start = fs;
        line_req = lr;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check({"idle_", tag}, (n >= 2000), 0);
    endtask

    task automatic read_words(input logic bank, input int idx, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            int b;
            int w;
            logic [127:0] e;
            b = i / 4;
            w = i % 4;
            @(posedge clk);
            #1;
            e = all_beats[idx * BEATS + b];
            buf_adr = {bank, BW'(b), 2'(w)};
            exp_word.push_back(e[32 * w +: 32]);
            adr_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        adr_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic [29:0] a, output int idx);
        exp_cmd.push_back(a);
        idx = n_cmd;
        n_cmd++;
    endtask

    task automatic check_underrun(input string tag);
`ifdef LINE_FETCH_UNDERRUN_EN
        check({"underrun_", tag}, underrun, (exp_ucnt != 0));
        check({"underrun_cnt_", tag}, underrun_cnt, exp_ucnt);
`else
        check({"underrun_", tag}, underrun, 0);
        check({"underrun_cnt_", tag}, underrun_cnt, 0);
`endif
    endtask

    initial begin : main
        logic [29:0] base;
        int prev_idx, idx, idx_a, idx_b, p0, n, errs;

        // Reset state, sampled while reset is held.
        @(posedge clk);
        @(negedge clk);
        check("rst_cmd_en", cmd_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_addr", cmd_byte_addr, 0);
        check("rst_buf_data", buf_data, 0);
        check("rst_disp_bank", disp_bank, 1);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_underrun", underrun, 0);
        check("rst_underrun_cnt", underrun_cnt, 0);
        check("cmd_instr", cmd_instr, 3'b001);
        check("cmd_bl", cmd_bl, 6'(BEATS - 1));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Line 0: low address bits must be ignored.
        base = 30'h0E7F00;
        fb_base = 30'h0E7F05;
        push_cmd(base, prev_idx);
        pulse(1, 0);
        wait_idle("line0");
        check("line_cnt_line0", line_cnt, 1);
        check("disp_bank_line0", disp_bank, 1);
        read_words(0, prev_idx, 0, 4 * BEATS);

        // Full frame with random MCB back-pressure.
        rand_stall = 1;
        for (int k = 1; k < LINES; k++) begin
            push_cmd(base + 30'(k) * LINE_BYTES, idx);
            pulse(0, 1);
            @(negedge clk);
            check("disp_bank", disp_bank, (k - 1) % 2);
            if (k < 4 || k % 128 == 0)
                read_words(disp_bank, prev_idx, 0, 4 * BEATS);
            else
                read_words(disp_bank, prev_idx, $urandom_range(0, 4 * BEATS - 1), 1);
            wait_idle("frame");
            check("line_cnt", line_cnt, k + 1);
            prev_idx = idx;
        end

        // Request beyond the last line: no fetch, no underrun.
        pulse(0, 1);
        @(negedge clk);
        check("disp_bank_last", disp_bank, 1);
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || cmd_en) errs++;
        end
        check("no_fetch_past_last", errs, 0);
        check("line_cnt_last", line_cnt, LINES);
        check_underrun("last");
        read_words(1, prev_idx, 0, 4 * BEATS);

        // Command FIFO full for 20 cycles; frame_start beats a coincident line_req.
        rand_stall = 0;
        @(negedge clk);
        force_full = 1;
        base = 30'h1234560;
        fb_base = base;
        push_cmd(base, idx);
        pulse(1, 1);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_en || !busy) errs++;
        end
        check("cmd_held_by_full", errs, 0);
        force_full = 0;
        alt_mode = 1;
        @(negedge clk);
        check("cmd_after_full_drop", cmd_en, 1);
        wait_idle("full");
        alt_mode = 0;
        check("line_cnt_full", line_cnt, 1);
        check_underrun("simultaneous");
        read_words(0, idx, 0, 4 * BEATS);

        // line_req during a fetch: counted, queued once, started right after DONE.
        rand_stall = 1;
        push_cmd(base + LINE_BYTES, idx_a);
        pulse(0, 1);
        @(negedge clk);
        check("disp_bank_ur0", disp_bank, 0);
        push_cmd(base + 2 * LINE_BYTES, idx_b);
        pulse(0, 1);
        exp_ucnt++;
        @(negedge clk);
        check("disp_bank_ur1", disp_bank, 1);
        pulse(0, 1);
        exp_ucnt++;
        @(negedge clk);
        check("disp_bank_ur2", disp_bank, 1);
        check_underrun("during");
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("first_fetch_done", busy, 0);
        @(negedge clk);
        check("pending_restart", busy, 1);
        wait_idle("pending");
        check("line_cnt_pending", line_cnt, 3);
        check_underrun("after");
        read_words(1, idx_a, 0, 4 * BEATS);
        read_words(0, idx_b, 0, 4 * BEATS);

        // frame_start after 3 beats: drain the rest, then line 0 at a wrapping base.
        rand_stall = 0;
        @(negedge clk);
        p0 = pops_total;
        pop_limit = p0 + 3;
        push_cmd(base + 3 * LINE_BYTES, idx);
        pulse(0, 1);
        n = 0;
        while (pops_total < p0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("three_beats_popped", pops_total, p0 + 3);
        fb_base = 30'h3FFFFF80;
        push_cmd(30'h3FFFFF80, idx);
        pulse(1, 0);
        @(negedge clk);
        pop_limit = 1 << 30;
        wait_idle("abort");
        check("drained_fifo", fifo.size(), 0);
        check("abort_pop_count", pops_total, p0 + 2 * BEATS);
        check("line_cnt_abort", line_cnt, 1);
        read_words(0, idx, 0, 4 * BEATS);
        push_cmd(30'h00000000, idx);
        pulse(0, 1);
        @(negedge clk);
        check("disp_bank_wrap", disp_bank, 0);
        wait_idle("wrap");
        check("line_cnt_wrap", line_cnt, 2);
        read_words(1, idx, 0, 4 * BEATS);

        repeat (5) @(negedge clk);
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("word_queue_drained", exp_word.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
